// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the core's memory-side blocks; holds the arbiter FSM state encoding.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read-only) and the LSQ with alternating priority.
// Downstream request is registered (issue at t+1); responses return combinationally from mem_resp.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 i_mem_read,
  input  logic [width-1:0]     i_mem_address,
  output logic                 i_mem_resp,
  output logic [width-1:0]     i_mem_rdata,
  input  logic                 lsq_mem_read,
  input  logic                 lsq_mem_write,
  input  logic [width-1:0]     lsq_mem_address,
  input  logic [width-1:0]     lsq_mem_wdata,
  input  logic [width/8-1:0]   lsq_mem_byte_enable,
  output logic                 lsq_mem_resp,
  output logic [width-1:0]     lsq_mem_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [width-1:0]     mem_address,
  output logic [width-1:0]     mem_wdata,
  output logic [width/8-1:0]   mem_byte_enable,
  input  logic                 mem_resp,
  input  logic [width-1:0]     mem_rdata
);

  arb_state_t state;
  logic       last_d;
  logic       drop_i;
  logic       i_req;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;

  assign i_req = i_mem_read;
  assign d_req = lsq_mem_read | lsq_mem_write;

  // In a SERVE state only the other side may be granted on the resp cycle,
  // so the just-served requester (still high) is never regranted.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req && (!d_req || last_d)) grant_i = 1'b1;
        else if (d_req)                  grant_d = 1'b1;
      end
      SERVE_I: if (mem_resp && d_req) grant_d = 1'b1;
      SERVE_D: if (mem_resp && i_req) grant_i = 1'b1;
      default: ;
    endcase
  end

  assign i_mem_resp    = !rst && (state == SERVE_I) && mem_resp && !drop_i && !flush;
  assign lsq_mem_resp  = !rst && (state == SERVE_D) && mem_resp;
  assign i_mem_rdata   = mem_rdata;
  assign lsq_mem_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_d          <= 1'b0;
      drop_i          <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else if (grant_i) begin
      state           <= SERVE_I;
      last_d          <= 1'b0;
      drop_i          <= flush;
      mem_read        <= 1'b1;
      mem_write       <= 1'b0;
      mem_address     <= i_mem_address;
      mem_wdata       <= '0;
      mem_byte_enable <= '1;
    end else if (grant_d) begin
      state           <= SERVE_D;
      last_d          <= 1'b1;
      drop_i          <= 1'b0;
      mem_read        <= lsq_mem_read;
      mem_write       <= lsq_mem_write;
      mem_address     <= lsq_mem_address;
      mem_wdata       <= lsq_mem_wdata;
      mem_byte_enable <= lsq_mem_byte_enable;
    end else if (state != IDLE && mem_resp) begin
      state     <= IDLE;
      drop_i    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else if (state == SERVE_I && flush) begin
      drop_i <= 1'b1;
    end
  end

endmodule
